eprom_programmer: RTL

EPROM_PROGRAMMER -- requirements
Module: eprom_programmer

---
 rtl/eprom_programmer.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/eprom_programmer.sv
// EPROM programmer: accepts read / program / erase+blank-check / blank-check
// commands from a host, sequences the EPROM strobes, verifies programmed words
// with bounded retries and reports a single response per command.
// Every output comes straight from a flop. The combinational process computes
// the next value of every register, and one sequential process loads them all.
module eprom_programmer #(
    parameter int                ADDR_W       = 4,
    parameter int                DATA_W       = 16,
    parameter int                PROG_CYCLES  = 4,
    parameter int                ERASE_CYCLES = 8,
    parameter int                MAX_RETRY    = 3,
    parameter logic [DATA_W-1:0] BLANK        = 16'hFFFF
) (
    input  logic              clk,
    input  logic              rst_n,
    // Host command channel. A command transfers on a rising edge where
    // cmd_valid and cmd_ready are both 1. The response channel uses the same
    // rule with rsp_valid/rsp_ready, and rsp_valid holds until it transfers.
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              busy,
    // EPROM side; mem_data is combinational from mem_addr
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_erase,
    input  logic [DATA_W-1:0] mem_data
);

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_PROG  = 2'b01;
    localparam logic [1:0] OP_ERASE = 2'b10;

    localparam int CYC_MAX = (PROG_CYCLES > ERASE_CYCLES) ? PROG_CYCLES : ERASE_CYCLES;
    localparam int CNT_W   = $clog2(CYC_MAX + 1);
    localparam int RETRY_W = $clog2(MAX_RETRY + 2);

    localparam logic [CNT_W-1:0]   PROG_LAST  = CNT_W'(PROG_CYCLES - 1);
    localparam logic [CNT_W-1:0]   ERASE_LAST = CNT_W'(ERASE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRY);
    localparam logic [ADDR_W-1:0]  ADDR_LAST  = '1;
    // Mismatch count saturates at the number of words, 2^ADDR_W
    localparam logic [ADDR_W:0]    BAD_MAX    = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        IDLE, READ, PROG, PVERIFY, ERASE, BCHECK, RESP
    } state_t;

    state_t              r_state,          w_state;
    logic                r_cmd_ready,      w_cmd_ready;
    logic                r_rsp_valid,      w_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_data,       w_rsp_data;
    logic                r_rsp_err,        w_rsp_err;
    logic                r_busy,           w_busy;
    logic [ADDR_W-1:0]   r_mem_addr,       w_mem_addr;
    logic                r_mem_we,         w_mem_we;
    logic [DATA_W-1:0]   r_mem_write_data, w_mem_write_data;
    logic                r_mem_erase,      w_mem_erase;
    logic [DATA_W-1:0]   r_wdata,          w_wdata;   // latched program data
    logic [RETRY_W-1:0]  r_retry,          w_retry;   // pulses after first failed verify
    logic [CNT_W-1:0]    r_cnt,            w_cnt;     // cycles spent in PROG / ERASE
    logic [ADDR_W:0]     r_bad,            w_bad;     // non-blank words seen in sweep

    assign cmd_ready      = r_cmd_ready;
    assign rsp_valid      = r_rsp_valid;
    assign rsp_data       = r_rsp_data;
    assign rsp_err        = r_rsp_err;
    assign busy           = r_busy;
    assign mem_addr       = r_mem_addr;
    assign mem_we         = r_mem_we;
    assign mem_write_data = r_mem_write_data;
    assign mem_erase      = r_mem_erase;

    // Next-state and next-output logic; strobes default low, everything else holds
    always_comb begin
        w_state          = r_state;
        w_cmd_ready      = 1'b0;
        w_rsp_valid      = r_rsp_valid;
        w_rsp_data       = r_rsp_data;
        w_rsp_err        = r_rsp_err;
        w_mem_addr       = r_mem_addr;
        w_mem_we         = 1'b0;
        w_mem_write_data = r_mem_write_data;
        w_mem_erase      = 1'b0;
        w_wdata          = r_wdata;
        w_retry          = r_retry;
        w_cnt            = r_cnt;
        w_bad            = r_bad;

        case (r_state)
            IDLE: begin
                w_cmd_ready = 1'b1;
                if (cmd_valid && r_cmd_ready) begin
                    w_cmd_ready = 1'b0;
                    w_wdata     = cmd_wdata;
                    w_retry     = '0;
                    w_cnt       = '0;
                    w_bad       = '0;
                    case (cmd_op)
                        OP_READ: begin
                            w_state    = READ;
                            w_mem_addr = cmd_addr;
                        end
                        OP_PROG: begin
                            w_state          = PROG;
                            w_mem_addr       = cmd_addr;
                            w_mem_we         = 1'b1;
                            w_mem_write_data = cmd_wdata;
                        end
                        OP_ERASE: begin
                            w_state     = ERASE;
                            w_mem_erase = 1'b1;
                        end
                        default: begin
                            // blank-check only: sweep starts right away
                            w_state    = BCHECK;
                            w_mem_addr = '0;
                        end
                    endcase
                end
            end

            READ: begin
                w_state     = RESP;
                w_rsp_valid = 1'b1;
                w_rsp_data  = mem_data;
                w_rsp_err   = 1'b0;
            end

            PROG: begin
                if (r_cnt == PROG_LAST) begin
                    w_state = PVERIFY;
                    w_cnt   = '0;
                end else begin
                    w_mem_we = 1'b1;
                    w_cnt    = r_cnt + CNT_W'(1);
                end
            end

            PVERIFY: begin
                if (mem_data == r_wdata) begin
                    w_state     = RESP;
                    w_rsp_valid = 1'b1;
                    w_rsp_data  = mem_data;
                    w_rsp_err   = 1'b0;
                end else if (r_retry != RETRY_MAX) begin
                    w_state  = PROG;
                    w_retry  = r_retry + RETRY_W'(1);
                    w_mem_we = 1'b1;
                    w_cnt    = '0;
                end else begin
                    // out of retries: report what the word actually holds
                    w_state     = RESP;
                    w_rsp_valid = 1'b1;
                    w_rsp_data  = mem_data;
                    w_rsp_err   = 1'b1;
                end
            end

            ERASE: begin
                if (r_cnt == ERASE_LAST) begin
                    w_state    = BCHECK;
                    w_mem_addr = '0;
                    w_cnt      = '0;
                end else begin
                    w_mem_erase = 1'b1;
                    w_cnt       = r_cnt + CNT_W'(1);
                end
            end

            BCHECK: begin
                // the sweep always covers every word, even after a mismatch
                if ((mem_data != BLANK) && (r_bad != BAD_MAX)) begin
                    w_bad = r_bad + {{ADDR_W{1'b0}}, 1'b1};
                end
                if (r_mem_addr == ADDR_LAST) begin
                    w_state     = RESP;
                    w_rsp_valid = 1'b1;
                    w_rsp_data  = DATA_W'(w_bad);
                    w_rsp_err   = (w_bad != '0);
                end else begin
                    w_mem_addr = r_mem_addr + ADDR_W'(1);
                end
            end

            RESP: begin
                if (rsp_ready) begin
                    w_state     = IDLE;
                    w_rsp_valid = 1'b0;
                    w_cmd_ready = 1'b1;
                end
            end

            default: begin
                w_state = IDLE;
            end
        endcase

        w_busy = (w_state != IDLE);
    end

    // State and output registers; reset aborts any operation and drops the strobes at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= IDLE;
            r_cmd_ready      <= 1'b0;
            r_rsp_valid      <= 1'b0;
            r_rsp_data       <= '0;
            r_rsp_err        <= 1'b0;
            r_busy           <= 1'b0;
            r_mem_addr       <= '0;
            r_mem_we         <= 1'b0;
            r_mem_write_data <= '0;
            r_mem_erase      <= 1'b0;
            r_wdata          <= '0;
            r_retry          <= '0;
            r_cnt            <= '0;
            r_bad            <= '0;
        end else begin
            r_state          <= w_state;
            r_cmd_ready      <= w_cmd_ready;
            r_rsp_valid      <= w_rsp_valid;
            r_rsp_data       <= w_rsp_data;
            r_rsp_err        <= w_rsp_err;
            r_busy           <= w_busy;
            r_mem_addr       <= w_mem_addr;
            r_mem_we         <= w_mem_we;
            r_mem_write_data <= w_mem_write_data;
            r_mem_erase      <= w_mem_erase;
            r_wdata          <= w_wdata;
            r_retry          <= w_retry;
            r_cnt            <= w_cnt;
            r_bad            <= w_bad;
        end
    end

endmodule
